// File: rtl/bullet_ctrl.sv
// Single-bullet lifetime controller: spawn on fire, per-frame motion, retire on hit
// or screen exit, and sprite-ROM read-out with a registered pixel for the mixer.
module bullet_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int SPRITE   = 6,
  parameter int SPEED    = 4,
  parameter int DIR      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] fire_x,
  input  logic [9:0] fire_y,
  output logic       fire_ack,
  input  logic       hit,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic [2:0] rom_x,
  output logic [2:0] rom_y,
  output logic       rom_en,
  input  logic       rom_data,
  output logic       pixel,
  output logic       active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y
);

  localparam logic [10:0] L_SPRITE = 11'(SPRITE);
  localparam logic [10:0] L_SPEED  = 11'(SPEED);
  localparam logic [10:0] L_Y_MAX  = 11'(SCREEN_H - SPRITE);
  localparam logic [9:0]  L_STEP   = 10'(SPEED);

  typedef enum logic {IDLE, FLY} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_bullet_x, r_bullet_y;
  logic [9:0]  w_bullet_x_nxt, w_bullet_y_nxt;
  logic        r_fire_ack, w_fire_ack_nxt;
  logic        r_pixel;

  logic [10:0] w_y_down;
  logic [10:0] w_hc, w_vc, w_bx, w_by;
  logic        w_in_x, w_in_y, w_inside;
  logic [2:0]  w_dx, w_dy;

  // 11-bit views so the +SPEED / +SPRITE bounds never wrap at 1023
  assign w_hc     = {1'b0, hcount};
  assign w_vc     = {1'b0, vcount};
  assign w_bx     = {1'b0, r_bullet_x};
  assign w_by     = {1'b0, r_bullet_y};
  assign w_y_down = w_by + L_SPEED;

  assign w_in_x   = (w_hc >= w_bx) && (w_hc < w_bx + L_SPRITE);
  assign w_in_y   = (w_vc >= w_by) && (w_vc < w_by + L_SPRITE);
  assign w_inside = (r_state == FLY) && w_in_x && w_in_y;

  // Offset within the sprite is < 8, so only the low bits of the difference matter
  assign w_dx = hcount[2:0] - r_bullet_x[2:0];
  assign w_dy = vcount[2:0] - r_bullet_y[2:0];

  assign rom_en   = w_inside;
  assign rom_x    = w_inside ? w_dx : 3'd0;
  assign rom_y    = w_inside ? w_dy : 3'd0;
  assign pixel    = r_pixel;
  assign fire_ack = r_fire_ack;
  assign active   = (r_state == FLY);
  assign bullet_x = r_bullet_x;
  assign bullet_y = r_bullet_y;

  always_comb begin
    w_state_nxt    = r_state;
    w_bullet_x_nxt = r_bullet_x;
    w_bullet_y_nxt = r_bullet_y;
    w_fire_ack_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (fire) begin
          w_bullet_x_nxt = fire_x;
          w_bullet_y_nxt = fire_y;
          w_fire_ack_nxt = 1'b1;
          w_state_nxt    = FLY;
        end
      end
      FLY: begin
        // A hit wins over motion and freezes the last position
        if (hit) begin
          w_state_nxt = IDLE;
        end else if (frame_tick) begin
          if (DIR == 0) begin
            if (w_by < L_SPEED) w_state_nxt = IDLE;
            else                w_bullet_y_nxt = r_bullet_y - L_STEP;
          end else begin
            if (w_y_down > L_Y_MAX) w_state_nxt = IDLE;
            else                    w_bullet_y_nxt = w_y_down[9:0];
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bullet_x <= 10'd0;
      r_bullet_y <= 10'd0;
      r_fire_ack <= 1'b0;
      r_pixel    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bullet_x <= w_bullet_x_nxt;
      r_bullet_y <= w_bullet_y_nxt;
      r_fire_ack <= w_fire_ack_nxt;
      r_pixel    <= w_inside & rom_data;
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: one upward and one downward instance share stimulus and are
// checked by directed scenarios and a randomized run against a behavioural model.
module tb_bullet_ctrl;

  localparam int SCREEN_H = 480;
  localparam int SPRITE   = 6;
  localparam int SPEED    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, fire, hit;
  logic [9:0] fire_x, fire_y, hcount, vcount;

  logic [1:0] o_ack, o_en, o_pix, o_act, rom_d;
  logic [2:0] o_rx [2];
  logic [2:0] o_ry [2];
  logic [9:0] o_bx [2];
  logic [9:0] o_by [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Bullet sprite: a two-pixel wide vertical bar in columns 2 and 3
  function automatic logic rom_bit(input logic [2:0] x);
    return (x == 3'd2) || (x == 3'd3);
  endfunction

  assign rom_d[0] = rom_bit(o_rx[0]);
  assign rom_d[1] = rom_bit(o_rx[1]);

  bullet_ctrl #(.SCREEN_H(SCREEN_H), .SPRITE(SPRITE), .SPEED(SPEED), .DIR(0)) u_up (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .fire_ack(o_ack[0]), .hit(hit),
    .hcount(hcount), .vcount(vcount), .rom_x(o_rx[0]), .rom_y(o_ry[0]),
    .rom_en(o_en[0]), .rom_data(rom_d[0]), .pixel(o_pix[0]), .active(o_act[0]),
    .bullet_x(o_bx[0]), .bullet_y(o_by[0]));

  bullet_ctrl #(.SCREEN_H(SCREEN_H), .SPRITE(SPRITE), .SPEED(SPEED), .DIR(1)) u_dn (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .fire_ack(o_ack[1]), .hit(hit),
    .hcount(hcount), .vcount(vcount), .rom_x(o_rx[1]), .rom_y(o_ry[1]),
    .rom_en(o_en[1]), .rom_data(rom_d[1]), .pixel(o_pix[1]), .active(o_act[1]),
    .bullet_x(o_bx[1]), .bullet_y(o_by[1]));

  // Behavioural reference: index 0 travels up, index 1 travels down
  bit m_act [2];
  bit m_ack [2];
  bit m_pix [2];
  int m_bx  [2];
  int m_by  [2];

  function automatic int m_dx(input int d);
    return int'(hcount) - m_bx[d];
  endfunction

  function automatic int m_dy(input int d);
    return int'(vcount) - m_by[d];
  endfunction

  function automatic bit m_inside(input int d);
    return m_act[d] && m_dx(d) >= 0 && m_dx(d) < SPRITE && m_dy(d) >= 0 && m_dy(d) < SPRITE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0; m_ack[d] <= 1'b0; m_pix[d] <= 1'b0;
        m_bx[d]  <= 0;    m_by[d]  <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_pix[d] <= m_inside(d) && (m_dx(d) == 2 || m_dx(d) == 3);
        m_ack[d] <= !m_act[d] && fire;
        if (!m_act[d]) begin
          if (fire) begin
            m_act[d] <= 1'b1;
            m_bx[d]  <= int'(fire_x);
            m_by[d]  <= int'(fire_y);
          end
        end else if (hit) begin
          m_act[d] <= 1'b0;
        end else if (frame_tick) begin
          if (d == 0) begin
            if (m_by[d] - SPEED < 0) m_act[d] <= 1'b0;
            else                     m_by[d]  <= m_by[d] - SPEED;
          end else begin
            if (m_by[d] + SPEED + SPRITE > SCREEN_H) m_act[d] <= 1'b0;
            else                                     m_by[d]  <= m_by[d] + SPEED;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fire = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    fire_x = '0; fire_y = '0; hcount = '0; vcount = '0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [9:0] x, input logic [9:0] y);
    fire = 1'b1; fire_x = x; fire_y = y;
    tick();
    fire = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    n_checks++; if (o_act !== 2'b00) begin n_errors++; $display("FAIL reset_active got=%b exp=00", o_act); end
    n_checks++; if (o_ack !== 2'b00) begin n_errors++; $display("FAIL reset_ack got=%b exp=00", o_ack); end
    n_checks++; if (o_pix !== 2'b00) begin n_errors++; $display("FAIL reset_pixel got=%b exp=00", o_pix); end
    n_checks++; if (o_en !== 2'b00) begin n_errors++; $display("FAIL reset_rom_en got=%b exp=00", o_en); end
    n_checks++; if (o_bx[0] !== 10'd0 || o_by[0] !== 10'd0) begin n_errors++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", o_bx[0], o_by[0]); end
    n_checks++; if (o_rx[0] !== 3'd0 || o_ry[0] !== 3'd0) begin n_errors++; $display("FAIL reset_rom_xy got=%0d,%0d exp=0,0", o_rx[0], o_ry[0]); end
    #10;
    rst_n = 1'b1;
    // Mid-flight reset with the scan inside the sprite so pixel is high beforehand
    launch(10'd60, 10'd200);
    hcount = 10'd62; vcount = 10'd200;
    #1;
    n_checks++; if (o_en[0] !== 1'b1) begin n_errors++; $display("FAIL midreset_pre_en got=%b exp=1", o_en[0]); end
    tick();
    n_checks++; if (o_pix[0] !== 1'b1) begin n_errors++; $display("FAIL midreset_pre_pixel got=%b exp=1", o_pix[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_act[0] !== 1'b0) begin n_errors++; $display("FAIL midreset_active got=%b exp=0", o_act[0]); end
    n_checks++; if (o_pix[0] !== 1'b0) begin n_errors++; $display("FAIL midreset_pixel got=%b exp=0", o_pix[0]); end
    n_checks++; if (o_en[0] !== 1'b0) begin n_errors++; $display("FAIL midreset_rom_en got=%b exp=0", o_en[0]); end
    n_checks++; if (o_by[0] !== 10'd0) begin n_errors++; $display("FAIL midreset_y got=%0d exp=0", o_by[0]); end
    rst_n = 1'b1;
  endtask

  task automatic test_fire();
    int acks;
    do_reset();
    acks = 0;
    fire = 1'b1; fire_x = 10'd100; fire_y = 10'd400;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_ack[0] === 1'b1) acks++;
    end
    fire = 1'b0;
    n_checks++; if (acks != 1) begin n_errors++; $display("FAIL fire_ack_count got=%0d exp=1", acks); end
    n_checks++; if (o_act[0] !== 1'b1) begin n_errors++; $display("FAIL fire_active got=%b exp=1", o_act[0]); end
    n_checks++; if (o_bx[0] !== 10'd100 || o_by[0] !== 10'd400) begin n_errors++; $display("FAIL fire_pos got=%0d,%0d exp=100,400", o_bx[0], o_by[0]); end
    for (int i = 0; i < 3; i++) pulse_tick();
    n_checks++; if (o_by[0] !== 10'd388) begin n_errors++; $display("FAIL fire_move_y got=%0d exp=388", o_by[0]); end
    n_checks++; if (o_bx[0] !== 10'd100) begin n_errors++; $display("FAIL fire_move_x got=%0d exp=100", o_bx[0]); end
  endtask

  task automatic test_top_exit();
    do_reset();
    launch(10'd50, 10'd5);
    pulse_tick();
    n_checks++; if (o_by[0] !== 10'd1 || o_act[0] !== 1'b1) begin n_errors++; $display("FAIL top_step got=y%0d act%b exp=y1 act1", o_by[0], o_act[0]); end
    pulse_tick();
    n_checks++; if (o_act[0] !== 1'b0) begin n_errors++; $display("FAIL top_exit got=%b exp=0", o_act[0]); end
    fire = 1'b1; fire_x = 10'd20; fire_y = 10'd30;
    tick();
    fire = 1'b0;
    n_checks++; if (o_ack[0] !== 1'b1 || o_act[0] !== 1'b1) begin n_errors++; $display("FAIL top_refire got=ack%b act%b exp=ack1 act1", o_ack[0], o_act[0]); end
    n_checks++; if (o_by[0] !== 10'd30) begin n_errors++; $display("FAIL top_refire_y got=%0d exp=30", o_by[0]); end
  endtask

  task automatic test_render();
    logic exp_en;
    logic exp_pix;
    do_reset();
    launch(10'd100, 10'd388);
    vcount = 10'd388;
    for (int h = 98; h <= 107; h++) begin
      hcount = 10'(h);
      #1;
      exp_en  = (h >= 100) && (h <= 105);
      exp_pix = (h == 102) || (h == 103);
      n_checks++; if (o_en[0] !== exp_en) begin n_errors++; $display("FAIL render_en h=%0d got=%b exp=%b", h, o_en[0], exp_en); end
      n_checks++; if (o_rx[0] !== (exp_en ? 3'(h - 100) : 3'd0)) begin n_errors++; $display("FAIL render_rom_x h=%0d got=%0d", h, o_rx[0]); end
      n_checks++; if (o_ry[0] !== 3'd0) begin n_errors++; $display("FAIL render_rom_y h=%0d got=%0d exp=0", h, o_ry[0]); end
      tick();
      n_checks++; if (o_pix[0] !== exp_pix) begin n_errors++; $display("FAIL render_pixel h=%0d got=%b exp=%b", h, o_pix[0], exp_pix); end
    end
  endtask

  task automatic test_hit();
    do_reset();
    launch(10'd40, 10'd300);
    hit = 1'b1; frame_tick = 1'b1; fire = 1'b1; fire_y = 10'd10;
    tick();
    hit = 1'b0; frame_tick = 1'b0; fire = 1'b0;
    n_checks++; if (o_act[0] !== 1'b0) begin n_errors++; $display("FAIL hit_active got=%b exp=0", o_act[0]); end
    n_checks++; if (o_by[0] !== 10'd300) begin n_errors++; $display("FAIL hit_y got=%0d exp=300", o_by[0]); end
    n_checks++; if (o_ack[0] !== 1'b0) begin n_errors++; $display("FAIL hit_fire_ack got=%b exp=0", o_ack[0]); end
    tick();
    n_checks++; if (o_ack[0] !== 1'b0 || o_pix[0] !== 1'b0) begin n_errors++; $display("FAIL hit_after got=ack%b pix%b exp=0,0", o_ack[0], o_pix[0]); end
  endtask

  task automatic test_down_boundary();
    int hs [8] = '{1018, 1019, 1020, 1021, 1022, 1023, 0, 1};
    logic exp_en;
    do_reset();
    launch(10'd1020, 10'd468);
    pulse_tick();
    n_checks++; if (o_by[1] !== 10'd472 || o_act[1] !== 1'b1) begin n_errors++; $display("FAIL down_step got=y%0d act%b exp=y472 act1", o_by[1], o_act[1]); end
    vcount = 10'd473;
    for (int i = 0; i < 8; i++) begin
      hcount = 10'(hs[i]);
      #1;
      exp_en = (hs[i] >= 1020);
      n_checks++; if (o_en[1] !== exp_en) begin n_errors++; $display("FAIL edge_en h=%0d got=%b exp=%b", hs[i], o_en[1], exp_en); end
      n_checks++; if (o_rx[1] !== (exp_en ? 3'(hs[i] - 1020) : 3'd0) || o_ry[1] !== (exp_en ? 3'd1 : 3'd0)) begin n_errors++; $display("FAIL edge_rom_xy h=%0d got=%0d,%0d", hs[i], o_rx[1], o_ry[1]); end
    end
    pulse_tick();
    n_checks++; if (o_act[1] !== 1'b0) begin n_errors++; $display("FAIL down_exit got=%b exp=0", o_act[1]); end
    n_checks++; if (o_by[1] !== 10'd472) begin n_errors++; $display("FAIL down_exit_y got=%0d exp=472", o_by[1]); end
  endtask

  task automatic test_random();
    int d;
    logic       exp_en;
    logic [2:0] exp_rx, exp_ry;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fire       = ($urandom_range(0, 7) == 0);
      hit        = ($urandom_range(0, 31) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      fire_x     = 10'($urandom_range(0, 1023));
      fire_y     = 10'($urandom_range(0, 479));
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        hcount = 10'(m_bx[d] + int'($urandom_range(0, 9)) - 2);
        vcount = 10'(m_by[d] + int'($urandom_range(0, 9)) - 2);
      end else begin
        hcount = 10'($urandom_range(0, 1023));
        vcount = 10'($urandom_range(0, 1023));
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_en = m_inside(k);
        exp_rx = exp_en ? 3'(m_dx(k)) : 3'd0;
        exp_ry = exp_en ? 3'(m_dy(k)) : 3'd0;
        n_checks++; if (o_en[k] !== exp_en || o_rx[k] !== exp_rx || o_ry[k] !== exp_ry) begin
          n_errors++; $display("FAIL rand_rom[%0d] c=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, c, o_en[k], o_rx[k], o_ry[k], exp_en, exp_rx, exp_ry);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (o_act[k] !== m_act[k] || o_ack[k] !== m_ack[k] || o_pix[k] !== m_pix[k]) begin
          n_errors++; $display("FAIL rand_ctl[%0d] c=%0d got=act%b ack%b pix%b exp=act%b ack%b pix%b", k, c, o_act[k], o_ack[k], o_pix[k], m_act[k], m_ack[k], m_pix[k]);
        end
        n_checks++; if (int'(o_bx[k]) != m_bx[k] || int'(o_by[k]) != m_by[k]) begin
          n_errors++; $display("FAIL rand_pos[%0d] c=%0d got=%0d,%0d exp=%0d,%0d", k, c, o_bx[k], o_by[k], m_bx[k], m_by[k]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fire();
    test_top_exit();
    test_render();
    test_hit();
    test_down_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
